// File: rtl/mem_port_arbiter_if.sv
// Line-wide memory port bundle: I-cache and D-cache request sides plus the shared memory side.
// master is the cache/memory environment, slave is the arbiter.
interface mem_port_arbiter_if;
  logic         i_read;
  logic         i_write;
  logic [27:0]  i_addr;
  logic [127:0] i_wdata;
  logic [127:0] i_rdata;
  logic         i_ready;

  logic         d_read;
  logic         d_write;
  logic [27:0]  d_addr;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_ready;

  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output i_read, i_write, i_addr, i_wdata,
    output d_read, d_write, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  i_read, i_write, i_addr, i_wdata,
    input  d_read, d_write, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 128-bit memory port between I-cache and D-cache: registered grant,
// owner-only ready/rdata routing, one-cycle bus gap, contention count and sticky timeout flag.
module mem_port_arbiter #(
  parameter bit D_PRIORITY = 1'b1,
  parameter int TIMEOUT    = 1023,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0]  contention_cnt,
  output logic              err_timeout
);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    GAP    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             i_req, d_req, grant_d, busy;
  logic             i_ready_c, d_ready_c;
  logic             last_d_q;
  logic             mem_read_q, mem_write_q;
  logic [27:0]      mem_addr_q;
  logic [127:0]     mem_wdata_q;
  logic [127:0]     i_rdata_q, d_rdata_q;
  logic [15:0]      wait_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign i_req = bus.i_read | bus.i_write;
  assign d_req = bus.d_read | bus.d_write;
  assign busy  = (state_q == BUSY_I) || (state_q == BUSY_D);

  // On a tie, fixed priority picks D; round-robin picks whoever was not granted last.
  assign grant_d = d_req & (~i_req | D_PRIORITY | ~last_d_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:           if (i_req || d_req) state_d = grant_d ? BUSY_D : BUSY_I;
      BUSY_I, BUSY_D: if (bus.mem_ready) state_d = GAP;
      GAP:            state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Ready is combinational from mem_ready and suppressed while reset is held.
  always_comb begin
    i_ready_c = rst_n & (state_q == BUSY_I) & bus.mem_ready;
    d_ready_c = rst_n & (state_q == BUSY_D) & bus.mem_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      wait_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state_q == IDLE && i_req && d_req && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);

      if (state_q == IDLE && (i_req || d_req)) begin
        last_d_q    <= grant_d;
        mem_addr_q  <= grant_d ? bus.d_addr  : bus.i_addr;
        mem_wdata_q <= grant_d ? bus.d_wdata : bus.i_wdata;
        mem_write_q <= grant_d ? bus.d_write : bus.i_write;
        mem_read_q  <= grant_d ? (bus.d_read & ~bus.d_write) : (bus.i_read & ~bus.i_write);
      end

      if (busy) begin
        if (wait_q != 16'hFFFF) wait_q <= wait_q + 16'd1;
        if (!bus.mem_ready && wait_q >= TIMEOUT_LAST) err_q <= 1'b1;
        if (bus.mem_ready) begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      end else begin
        wait_q <= '0;
      end

      if (i_ready_c) i_rdata_q <= bus.mem_rdata;
      if (d_ready_c) d_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.i_ready   = i_ready_c;
  assign bus.d_ready   = d_ready_c;
  assign bus.i_rdata   = i_ready_c ? bus.mem_rdata : i_rdata_q;
  assign bus.d_rdata   = d_ready_c ? bus.mem_rdata : d_rdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign contention_cnt = cnt_q;
  assign err_timeout    = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a fixed-priority instance and a round-robin/short-timeout instance
// share one stimulus and are compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int PH_IDLE = 0;
  localparam int PH_I    = 1;
  localparam int PH_D    = 2;
  localparam int PH_GAP  = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read, i_write, d_read, d_write, mem_ready;
  logic [27:0]  i_addr, d_addr;
  logic [127:0] i_wdata, d_wdata, mem_rdata;

  logic         o_mrd [2];
  logic         o_mwr [2];
  logic         o_ir  [2];
  logic         o_dr  [2];
  logic         o_err [2];
  logic [27:0]  o_addr[2];
  logic [127:0] o_mwd [2];
  logic [127:0] o_ird [2];
  logic [127:0] o_drd [2];
  logic [15:0]  o_cnt [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CW = (g == 0) ? 16 : 2;
    mem_port_arbiter_if bus ();
    logic [CW-1:0] cnt;
    logic          err;

    assign bus.i_read    = i_read;
    assign bus.i_write   = i_write;
    assign bus.i_addr    = i_addr;
    assign bus.i_wdata   = i_wdata;
    assign bus.d_read    = d_read;
    assign bus.d_write   = d_write;
    assign bus.d_addr    = d_addr;
    assign bus.d_wdata   = d_wdata;
    assign bus.mem_rdata = mem_rdata;
    assign bus.mem_ready = mem_ready;

    assign o_mrd[g]  = bus.mem_read;
    assign o_mwr[g]  = bus.mem_write;
    assign o_addr[g] = bus.mem_addr;
    assign o_mwd[g]  = bus.mem_wdata;
    assign o_ir[g]   = bus.i_ready;
    assign o_dr[g]   = bus.d_ready;
    assign o_ird[g]  = bus.i_rdata;
    assign o_drd[g]  = bus.d_rdata;
    assign o_cnt[g]  = 16'(cnt);
    assign o_err[g]  = err;

    if (g == 0) begin : g_pri
      mem_port_arbiter #(.D_PRIORITY(1'b1), .TIMEOUT(1023), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .contention_cnt(cnt), .err_timeout(err));
    end else begin : g_rr
      mem_port_arbiter #(.D_PRIORITY(1'b0), .TIMEOUT(8), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .contention_cnt(cnt), .err_timeout(err));
    end
  end

  // Reference model: one transaction view per instance.
  int           m_ph  [2];
  int           m_busy[2];
  int           m_cnt [2];
  bit           m_lastd[2];
  bit           m_err [2];
  bit           m_rd  [2];
  bit           m_wr  [2];
  logic [27:0]  m_addr[2];
  logic [127:0] m_wd  [2];
  logic [127:0] m_ird [2];
  logic [127:0] m_drd [2];

  function automatic bit dpri(input int k);  return (k == 0);             endfunction
  function automatic int tmo(input int k);   return (k == 0) ? 1023 : 8;  endfunction
  function automatic int cmax(input int k);  return (k == 0) ? 65535 : 3; endfunction
  function automatic logic [127:0] rnd128(); return {$urandom, $urandom, $urandom, $urandom}; endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_tick();
    for (int k = 0; k < 2; k++) begin
      bit ir, dr, pd;
      ir = i_read | i_write;
      dr = d_read | d_write;
      if (!rst_n) begin
        m_ph[k] = PH_IDLE; m_busy[k] = 0; m_cnt[k] = 0; m_lastd[k] = 0; m_err[k] = 0;
        m_rd[k] = 0; m_wr[k] = 0; m_addr[k] = '0; m_wd[k] = '0; m_ird[k] = '0; m_drd[k] = '0;
      end else if (m_ph[k] == PH_IDLE) begin
        if (ir && dr && m_cnt[k] < cmax(k)) m_cnt[k]++;
        if (ir || dr) begin
          pd = dr && (!ir || dpri(k) || !m_lastd[k]);
          m_lastd[k] = pd;
          m_wr[k]    = pd ? d_write : i_write;
          m_rd[k]    = pd ? (d_read && !d_write) : (i_read && !i_write);
          m_addr[k]  = pd ? d_addr : i_addr;
          m_wd[k]    = pd ? d_wdata : i_wdata;
          m_ph[k]    = pd ? PH_D : PH_I;
          m_busy[k]  = 0;
        end
      end else if (m_ph[k] == PH_GAP) begin
        m_ph[k] = PH_IDLE;
      end else begin
        m_busy[k]++;
        if (mem_ready) begin
          if (m_ph[k] == PH_I) m_ird[k] = mem_rdata;
          else                 m_drd[k] = mem_rdata;
          m_rd[k] = 0;
          m_wr[k] = 0;
          m_ph[k] = PH_GAP;
        end else if (m_busy[k] >= tmo(k)) begin
          m_err[k] = 1;
        end
      end
    end
  endtask

  task automatic eval_chk();
    bit           er, edr;
    logic [127:0] eird, edrd;
    string        t;
    #1;
    for (int k = 0; k < 2; k++) begin
      t    = (k == 0) ? "a." : "b.";
      er   = rst_n && (m_ph[k] == PH_I) && mem_ready;
      edr  = rst_n && (m_ph[k] == PH_D) && mem_ready;
      eird = er  ? mem_rdata : m_ird[k];
      edrd = edr ? mem_rdata : m_drd[k];
      chk({t, "mem_read"},  128'(o_mrd[k]),  128'(m_rd[k]));
      chk({t, "mem_write"}, 128'(o_mwr[k]),  128'(m_wr[k]));
      chk({t, "mem_addr"},  128'(o_addr[k]), 128'(m_addr[k]));
      chk({t, "mem_wdata"}, o_mwd[k], m_wd[k]);
      chk({t, "i_ready"},   128'(o_ir[k]),   128'(er));
      chk({t, "d_ready"},   128'(o_dr[k]),   128'(edr));
      chk({t, "i_rdata"},   o_ird[k], eird);
      chk({t, "d_rdata"},   o_drd[k], edrd);
      chk({t, "contention_cnt"}, 128'(o_cnt[k]), 128'(m_cnt[k]));
      chk({t, "err_timeout"},    128'(o_err[k]), 128'(m_err[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic step();
    eval_chk();
    tick();
  endtask

  initial begin
    logic [127:0] a5;
    logic [127:0] wd;
    int           gq[$];
    bit           got_i, got_d;
    int           r;
    a5 = {16{8'hA5}};

    rst_n = 1'b0; i_read = 0; i_write = 0; d_read = 0; d_write = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; mem_rdata = '0;
    tick();
    tick();

    // Reset state
    rst_n = 1'b1;
    eval_chk();
    chk("rst.mem_read", 128'(o_mrd[0]), 128'(0));
    chk("rst.mem_addr", 128'(o_addr[0]), 128'(0));
    chk("rst.cnt", 128'(o_cnt[0]), 128'(0));
    chk("rst.err", 128'(o_err[1]), 128'(0));
    tick();

    // Single D read, memory answers on the 5th busy cycle
    d_read = 1; d_addr = 28'h0000010;
    eval_chk();
    chk("t1.strobe_idle", 128'(o_mrd[0]), 128'(0));
    tick();
    for (int c = 0; c < 4; c++) begin
      eval_chk();
      chk("t1.mem_read", 128'(o_mrd[0]), 128'(1));
      chk("t1.mem_addr", 128'(o_addr[0]), 128'(28'h0000010));
      chk("t1.d_ready_wait", 128'(o_dr[0]), 128'(0));
      tick();
    end
    mem_ready = 1; mem_rdata = a5;
    eval_chk();
    chk("t1.d_ready", 128'(o_dr[0]), 128'(1));
    chk("t1.d_rdata", o_drd[0], a5);
    chk("t1.i_ready", 128'(o_ir[0]), 128'(0));
    tick();
    d_read = 0; mem_ready = 0; mem_rdata = '0;
    eval_chk();
    chk("t1.gap_read", 128'(o_mrd[0]), 128'(0));
    chk("t1.d_rdata_held", o_drd[0], a5);
    tick();
    step();

    // Simultaneous I read and D write, fixed priority serves D first
    wd = rnd128();
    i_read = 1; i_addr = 28'h0AAAAAA; d_write = 1; d_addr = 28'h0BBBBBB; d_wdata = wd;
    step();
    mem_ready = 1; mem_rdata = rnd128();
    eval_chk();
    chk("t2.mem_write", 128'(o_mwr[0]), 128'(1));
    chk("t2.mem_read", 128'(o_mrd[0]), 128'(0));
    chk("t2.mem_addr", 128'(o_addr[0]), 128'(28'h0BBBBBB));
    chk("t2.mem_wdata", o_mwd[0], wd);
    chk("t2.cnt", 128'(o_cnt[0]), 128'(1));
    chk("t2.d_ready", 128'(o_dr[0]), 128'(1));
    chk("t2.i_ready", 128'(o_ir[0]), 128'(0));
    tick();
    d_write = 0; mem_ready = 0;
    eval_chk();
    chk("t2.gap_write", 128'(o_mwr[0]), 128'(0));
    tick();
    eval_chk();
    chk("t2.idle_read", 128'(o_mrd[0]), 128'(0));
    tick();
    mem_ready = 1; mem_rdata = rnd128();
    eval_chk();
    chk("t2.i_mem_read", 128'(o_mrd[0]), 128'(1));
    chk("t2.i_mem_addr", 128'(o_addr[0]), 128'(28'h0AAAAAA));
    chk("t2.i_ready", 128'(o_ir[0]), 128'(1));
    chk("t2.cnt_after", 128'(o_cnt[0]), 128'(1));
    tick();
    i_read = 0; mem_ready = 0;
    step();
    step();

    // Round-robin from reset with both caches requesting continuously
    rst_n = 0;
    step();
    rst_n = 1;
    i_read = 1; i_addr = 28'h1111111; d_read = 1; d_addr = 28'h2222222; mem_ready = 1;
    for (int c = 0; c < 12; c++) begin
      mem_rdata = rnd128();
      eval_chk();
      if (o_dr[1]) gq.push_back(1);
      else if (o_ir[1]) gq.push_back(0);
      tick();
    end
    i_read = 0; d_read = 0; mem_ready = 0;
    eval_chk();
    chk("t3.grants", 128'(gq.size()), 128'(4));
    for (int i = 0; i < gq.size() && i < 4; i++)
      chk("t3.grant_order", 128'(gq[i]), 128'((i % 2 == 0) ? 1 : 0));
    chk("t3.cnt_pri", 128'(o_cnt[0]), 128'(4));
    chk("t3.cnt_sat", 128'(o_cnt[1]), 128'(3));
    tick();

    // D request arrives while I owns the port
    i_read = 1; i_addr = 28'h0333333;
    step();
    step();
    d_read = 1; d_addr = 28'h0444444;
    eval_chk();
    chk("t4.addr_hold", 128'(o_addr[0]), 128'(28'h0333333));
    tick();
    mem_ready = 1; mem_rdata = rnd128();
    eval_chk();
    chk("t4.addr_hold2", 128'(o_addr[0]), 128'(28'h0333333));
    chk("t4.i_ready", 128'(o_ir[0]), 128'(1));
    tick();
    i_read = 0; mem_ready = 0;
    eval_chk();
    chk("t4.gap_addr", 128'(o_addr[0]), 128'(28'h0333333));
    tick();
    eval_chk();
    chk("t4.idle_read", 128'(o_mrd[0]), 128'(0));
    tick();
    mem_ready = 1; mem_rdata = rnd128();
    eval_chk();
    chk("t4.d_granted", 128'(o_mrd[0]), 128'(1));
    chk("t4.d_addr", 128'(o_addr[0]), 128'(28'h0444444));
    tick();
    d_read = 0; mem_ready = 0;
    step();
    step();

    // Memory never answers: the TIMEOUT=8 instance flags after 8 busy cycles
    i_read = 1; i_addr = 28'h0555555;
    step();
    for (int c = 0; c < 8; c++) begin
      eval_chk();
      chk("t5.err_before", 128'(o_err[1]), 128'(0));
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      eval_chk();
      chk("t5.err_sticky", 128'(o_err[1]), 128'(1));
      chk("t5.mem_read", 128'(o_mrd[1]), 128'(1));
      chk("t5.err_long", 128'(o_err[0]), 128'(0));
      tick();
    end
    rst_n = 0; mem_ready = 1; mem_rdata = rnd128();
    eval_chk();
    chk("t5.rst_no_ready_a", 128'(o_ir[0]), 128'(0));
    chk("t5.rst_no_ready_b", 128'(o_ir[1]), 128'(0));
    tick();
    rst_n = 1; i_read = 0; mem_ready = 0;
    eval_chk();
    chk("t5.rst_err", 128'(o_err[1]), 128'(0));
    chk("t5.rst_read", 128'(o_mrd[1]), 128'(0));
    chk("t5.rst_addr", 128'(o_addr[1]), 128'(0));
    chk("t5.rst_cnt", 128'(o_cnt[0]), 128'(0));
    tick();

    // Randomized traffic; the caches follow the fixed-priority instance's handshake
    got_i = 0; got_d = 0;
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      if (got_i || !rst_n) begin
        i_read = 0; i_write = 0;
      end else if (!(i_read || i_write) && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 7);
        i_write = (r == 0); i_read = (r != 0) || ($urandom_range(0, 1) == 0);
        i_addr = 28'($urandom); i_wdata = rnd128();
      end
      if (got_d || !rst_n) begin
        d_read = 0; d_write = 0;
      end else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 7);
        d_write = (r < 3); d_read = (r >= 2);
        d_addr = 28'($urandom); d_wdata = rnd128();
      end
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = rnd128();
      eval_chk();
      got_i = o_ir[0];
      got_d = o_dr[0];
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 128-bit line-wide memory port between the I-cache and the D-cache miss/write-back interfaces.
- Each cache keeps its existing level-style handshake: it holds read or write until it sees ready.
- The arbiter picks one owner, registers and forwards that owner's request, and routes ready/rdata back to the owner only.
- It also inserts a one-cycle bus gap between transactions and flags a memory that never answers.

Parameters:
- D_PRIORITY, 1, 1: D-cache wins every simultaneous request. 0: round-robin on simultaneous requests.
- TIMEOUT, 1023, number of BUSY cycles without mem_ready before err_timeout is set. Range 1..65535.
- CNT_W, 16, width of the contention counter.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_read  in  1  I-cache line read request
i_write  in  1  I-cache line write request (normally 0)
i_addr  in  28  I-cache line address
i_wdata  in  128  I-cache write line
i_rdata  out  128  read line to I-cache
i_ready  out  1  I-cache transaction complete
d_read  in  1  D-cache line read request
d_write  in  1  D-cache line write-back request
d_addr  in  28  D-cache line address
d_wdata  in  128  D-cache write line
d_rdata  out  128  read line to D-cache
d_ready  out  1  D-cache transaction complete
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  28  memory line address
mem_wdata  out  128  memory write line
mem_rdata  in  128  memory read line
mem_ready  in  1  memory transaction complete
contention_cnt  out  CNT_W  count of cycles where both caches requested in IDLE
err_timeout  out  1  sticky: a transaction exceeded TIMEOUT

Behaviour:
- Reset is synchronous with rst_n low. Reset values:
  - state=IDLE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - last_grant=I, contention_cnt=0, err_timeout=0, wait counter=0.
  - i_ready=0, d_ready=0.
- Reset asserted mid-transaction drops mem_read/mem_write on the next edge. No ready is forwarded after that.
- A request is x_read|x_write. If both read and write are high, write takes precedence.
- States:
  - IDLE:
    - No requests: stay in IDLE.
    - One requester: go to BUSY_I or BUSY_D.
    - Both requesters: D_PRIORITY=1 picks D. D_PRIORITY=0 picks the requester that is not last_grant.
    - On the IDLE→BUSY edge: latch addr, wdata and r/w of the winner into mem_addr, mem_wdata, mem_read/mem_write. Update last_grant.
    - contention_cnt increments (saturating at all-ones) in every IDLE cycle where both requesters request.
  - BUSY_I / BUSY_D:
    - The registered mem strobes stay high and the wait counter increments.
    - When mem_ready=1: the owner's ready=1 combinationally in the same cycle. The owner's rdata=mem_rdata. Next state is GAP.
  - GAP:
    - Lasts exactly one cycle. mem_read and mem_write are 0 and the wait counter clears.
    - All requests are ignored, because requesters drop their request the cycle after ready.
    - Always returns to IDLE.
- The non-owner's ready is always 0. Its rdata is held at the last value delivered to it, from a register per side, reset 0.
- mem_ready in IDLE or GAP is ignored and forwarded nowhere.
- Grant is non-preemptive: a request arriving during BUSY waits. Minimum latency from request to mem strobe is 1 cycle.
- Back-to-back requests from the same cache are separated by at least the GAP cycle plus the IDLE cycle.
- Timeout:
  - The wait counter reaching TIMEOUT in BUSY sets err_timeout, which is sticky until reset.
  - The transaction is not aborted; the arbiter keeps waiting for mem_ready.
- mem_addr and mem_wdata hold their values after GAP until the next grant.

Test Plan:
- Only d_read=1 with addr 0x0000010. Memory answers ready after 5 cycles with rdata 0xA5..A5.
  → mem_read high one cycle after the request with mem_addr=0x0000010. d_ready=1 for 1 cycle with d_rdata=0xA5..A5. i_ready stays 0. Next cycle is GAP with mem_read=0.
- i_read and d_write both rise in the same cycle, D_PRIORITY=1.
  → D is served first: mem_write=1 with d_addr/d_wdata. I is served after GAP+IDLE. contention_cnt=1.
- D_PRIORITY=0, both caches request continuously for 4 transactions.
  → Grants alternate D, I, D, I starting from reset last_grant=I.
- I is in BUSY, d_read rises mid-transaction.
  → No change to mem_addr until i_ready. D is granted 2 cycles after i_ready.
- TIMEOUT=8, memory never asserts ready.
  → err_timeout=1 after 8 BUSY cycles and stays 1. mem_read stays high. Pulling rst_n low for 1 cycle clears everything to reset values.
